timer_counter8: RTL and testbench
=================================

# timer_counter8

8-bit timer/counter with a tick prescaler, overflow and compare-match flags, normal and CTC modes, and a toggling compare output. Sits directly downstream of the divided-clock generator. Its `tick_in` is the 50%-duty divided clock produced by that stage. The block runs entirely in the `clock50` domain. It supplies the emulated core with the TCNT/OCR/TOV/OCF behaviour of an ATmega32A Timer0.

## Interface
Parameters:
- `PRESCALE_W`, default 10: prescaler counter width; must hold 1023.

Ports:
- `clock50`, in, 1: the only clock; all state updates on its rising edge.
- `MR_n`, in, 1: reset; asynchronous, active-low.
- `tick_in`, in, 1: divided clock from the upstream generator; treated as asynchronous.
- `cs`, in, 3: clock select.
  - 0: stopped.
  - 1: /1, 2: /8, 3: /64, 4: /256, 5: /1024 of tick rising edges.
  - 6 and 7: stopped (reserved).
- `ctc`, in, 1: 0 = normal mode, 1 = clear-timer-on-compare mode.
- `ocr`, in, 8: compare value.
- `tcnt_we`, in, 1: write strobe for `tcnt_din`.
- `tcnt_din`, in, 8: counter write data.
- `tov_clr`, in, 1: clears `tov`.
- `ocf_clr`, in, 1: clears `ocf`.
- `tcnt`, out, 8: current count.
- `tov`, out, 1: overflow flag, sticky.
- `ocf`, out, 1: compare-match flag, sticky.
- `oc_out`, out, 1: toggles on every compare match.

## Operation
- **Tick synchronisation**
  - `tick_in` passes through a 2-flop synchroniser and a third edge register.
  - `tick_p` = sync2 & ~sync3 is a one-cycle pulse per tick rising edge.
- **Prescaler**
  - On each `tick_p`, with `cs` in 1..5, the prescaler increments.
  - When it equals N-1 (N = 1, 8, 64, 256, 1024), it wraps to 0 and asserts the count enable `cen` for that cycle.
  - `cs`=1 gives `cen` = `tick_p`.
- **Clock-select change**: any change of `cs`, detected by a registered copy, resets the prescaler to 0 that cycle. No `cen` is generated in that cycle.
- **Stopped**: `cs` = 0, 6 or 7 freezes the prescaler and `tcnt`.
- **Normal mode count event** (`cen`=1):
  - `tcnt` <= `tcnt`+1, modulo 256.
  - Transition 0xFF→0x00 sets `tov`.
- **CTC mode count event**:
  - If `tcnt` == `ocr`: `tcnt` <= 0. Otherwise `tcnt` <= `tcnt`+1.
  - `tov` is set only on a 0xFF→0x00 wrap, which is possible only when `ocr` < `tcnt` after a write.
- **Compare match**: a count event while `tcnt` == `ocr`, in either mode. It sets `ocf` and toggles `oc_out`.
- **CPU write**: `tcnt_we` loads `tcnt_din` and overrides a simultaneous count event. That event is lost and generates no match and no overflow.
- **Flag priority**: set beats clear. If `tov_clr` coincides with an overflow, `tov` stays 1. The same rule applies to `ocf`.
- **`ocr` = 0 in CTC**: `tcnt` holds 0, and every count event is a match.

## Timing
- **Reset values** (`MR_n` low, asynchronous):
  - `tcnt`=0x00, `tov`=0, `ocf`=0, `oc_out`=0.
  - Prescaler 0; synchroniser and edge registers 0; registered `cs` 0.
- **Tick-to-count latency**: with `tick_in` first sampled high at edge E0, `tick_p` is high during E1..E2, and `tcnt`, flags and `oc_out` update at E2.
- Minimum `tick_in` high and low times are 2 `clock50` periods each; faster ticks are undefined.
- Flags and `oc_out` change on the same edge as the `tcnt` update that causes them.
- Clears take effect on the edge where the strobe is sampled.
- **Reset mid-count**: all state returns to reset values immediately. The first post-reset tick edge counts normally.

## Structure
- **Package `timer_pkg`**:
  - `cs` encodings: `CS_STOP`, `CS_DIV1`, `CS_DIV8`, `CS_DIV64`, `CS_DIV256`, `CS_DIV1024`.
  - Mode constants `MODE_NORMAL`, `MODE_CTC`.
  - Prescale terminal-value function: `cs` → N-1.
- **Sub-module `tick_sync_edge`**: 3 flops with async active-low clear, output `tick_p`.
- Prescaler, counter, flags and `oc_out` live in the top module.

## Test plan
- **Reset**: hold `MR_n` low mid-count → all outputs 0 asynchronously. Release, `cs`=1, 3 ticks → `tcnt`=3, each update exactly 2 `clock50` edges after `tick_in` is sampled high.
- **Normal overflow**: `cs`=1, `tcnt` written 0xFE, 2 ticks → `tcnt` 0xFF then 0x00, `tov`=1. Pulse `tov_clr` → 0.
- **CTC**: `ctc`=1, `ocr`=4, `cs`=1, 12 ticks → sequence 0,1,2,3,4,0,1,…; `ocf` set at first wrap, `oc_out` toggles twice, `tov` never set.
- **Prescaler**: `cs`=2, 16 ticks → `tcnt`=2. Switch to `cs`=3 after 3 further ticks → prescaler restarts, next increment exactly 64 ticks later.
- **Collisions**:
  - `tcnt_we` (din 0x10) on the same cycle as a count event with `tcnt`=0xFF → `tcnt`=0x10, no `tov`.
  - `ocf_clr` coincident with a match → `ocf` stays 1.
- **Stopped/reserved**: `cs`=6, 20 ticks → `tcnt` and prescaler unchanged. `ctc`=1, `ocr`=0 → `tcnt` stays 0, `ocf` set on every count event.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared encodings and prescaler helpers for the 8-bit timer/counter.
package timer_pkg;

  localparam int unsigned PRESC_W = 10;

  localparam logic [2:0] CS_STOP    = 3'd0;
  localparam logic [2:0] CS_DIV1    = 3'd1;
  localparam logic [2:0] CS_DIV8    = 3'd2;
  localparam logic [2:0] CS_DIV64   = 3'd3;
  localparam logic [2:0] CS_DIV256  = 3'd4;
  localparam logic [2:0] CS_DIV1024 = 3'd5;

  localparam logic MODE_NORMAL = 1'b0;
  localparam logic MODE_CTC    = 1'b1;

  // Terminal prescaler value N-1 for a clock select; stopped codes map to 0.
  function automatic logic [PRESC_W-1:0] presc_terminal(input logic [2:0] cs_v);
    logic [PRESC_W-1:0] t;
    case (cs_v)
      CS_DIV1:    t = 10'd0;
      CS_DIV8:    t = 10'd7;
      CS_DIV64:   t = 10'd63;
      CS_DIV256:  t = 10'd255;
      CS_DIV1024: t = 10'd1023;
      default:    t = 10'd0;
    endcase
    return t;
  endfunction

  function automatic logic cs_running(input logic [2:0] cs_v);
    return (cs_v >= CS_DIV1) && (cs_v <= CS_DIV1024);
  endfunction

endpackage

// File: rtl/timer_counter8_tick_sync_edge.sv
// Two-flop synchroniser plus edge register; emits a one-cycle pulse per
// rising edge of the asynchronous tick input.
module tick_sync_edge
  import timer_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  output logic tick_p_o
);

  logic sync1_q, sync2_q, sync3_q;

  // Synchroniser chain and edge-detect history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= tick_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign tick_p_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/timer_counter8.sv
// 8-bit Timer0-style counter: tick prescaler, normal/CTC modes, sticky
// overflow and compare flags, and a toggling compare output.
module timer_counter8
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 10
) (
  input  logic       clock50,
  input  logic       MR_n,
  input  logic       tick_in,
  input  logic [2:0] cs,
  input  logic       ctc,
  input  logic [7:0] ocr,
  input  logic       tcnt_we,
  input  logic [7:0] tcnt_din,
  input  logic       tov_clr,
  input  logic       ocf_clr,
  output logic [7:0] tcnt,
  output logic       tov,
  output logic       ocf,
  output logic       oc_out
);

  logic                  tick_p_s;
  logic                  cen_s;
  logic                  match_s;
  logic                  wrap_s;
  logic [PRESCALE_W-1:0] term_s;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [2:0]            cs_q;
  logic [7:0]            tcnt_q, tcnt_d;
  logic                  tov_q, tov_d;
  logic                  ocf_q, ocf_d;
  logic                  oc_q, oc_d;

  tick_sync_edge u_sync (
    .clk_i    (clock50),
    .rst_ni   (MR_n),
    .tick_i   (tick_in),
    .tick_p_o (tick_p_s)
  );

  assign term_s = PRESCALE_W'(presc_terminal(cs));

  // Prescaler: a clock-select change restarts it and suppresses that cycle's enable.
  always_comb begin
    presc_d = presc_q;
    cen_s   = 1'b0;
    if (cs != cs_q) begin
      presc_d = '0;
    end else if (cs_running(cs) && tick_p_s) begin
      if (presc_q == term_s) begin
        presc_d = '0;
        cen_s   = 1'b1;
      end else begin
        presc_d = presc_q + PRESCALE_W'(1);
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Counter and flags; a CPU write swallows a coincident count event entirely.
  always_comb begin
    tcnt_d  = tcnt_q;
    match_s = 1'b0;
    wrap_s  = 1'b0;
    if (tcnt_we) begin
      tcnt_d = tcnt_din;
    end else if (cen_s) begin
      match_s = (tcnt_q == ocr);
      if ((ctc == MODE_CTC) && match_s) begin
        tcnt_d = 8'h00;
      end else begin
        tcnt_d = tcnt_q + 8'd1;
        wrap_s = (tcnt_q == 8'hFF);
      end
    end else begin
      tcnt_d = tcnt_q;
    end

    if (wrap_s) begin
      tov_d = 1'b1;
    end else if (tov_clr) begin
      tov_d = 1'b0;
    end else begin
      tov_d = tov_q;
    end

    if (match_s) begin
      ocf_d = 1'b1;
      oc_d  = ~oc_q;
    end else if (ocf_clr) begin
      ocf_d = 1'b0;
      oc_d  = oc_q;
    end else begin
      ocf_d = ocf_q;
      oc_d  = oc_q;
    end
  end

  // State registers.
  always_ff @(posedge clock50 or negedge MR_n) begin
    if (!MR_n) begin
      presc_q <= '0;
      cs_q    <= CS_STOP;
      tcnt_q  <= 8'h00;
      tov_q   <= 1'b0;
      ocf_q   <= 1'b0;
      oc_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cs_q    <= cs;
      tcnt_q  <= tcnt_d;
      tov_q   <= tov_d;
      ocf_q   <= ocf_d;
      oc_q    <= oc_d;
    end
  end

  assign tcnt   = tcnt_q;
  assign tov    = tov_q;
  assign ocf    = ocf_q;
  assign oc_out = oc_q;

endmodule

// File: tb/tb_timer_counter8.sv
// Directed self-checking bench for timer_counter8.
module tb_timer_counter8;

  logic       clock50;
  logic       MR_n;
  logic       tick_in;
  logic [2:0] cs;
  logic       ctc;
  logic [7:0] ocr;
  logic       tcnt_we;
  logic [7:0] tcnt_din;
  logic       tov_clr;
  logic       ocf_clr;
  logic [7:0] tcnt;
  logic       tov;
  logic       ocf;
  logic       oc_out;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_oc;

  timer_counter8 #(.PRESCALE_W(10)) dut (
    .clock50  (clock50),
    .MR_n     (MR_n),
    .tick_in  (tick_in),
    .cs       (cs),
    .ctc      (ctc),
    .ocr      (ocr),
    .tcnt_we  (tcnt_we),
    .tcnt_din (tcnt_din),
    .tov_clr  (tov_clr),
    .ocf_clr  (ocf_clr),
    .tcnt     (tcnt),
    .tov      (tov),
    .ocf      (ocf),
    .oc_out   (oc_out)
  );

  initial clock50 = 1'b0;
  always #5 clock50 = ~clock50;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock50);
  endtask

  // One tick: high 4 cycles, low 3. Strobes are presented on the cycle of the
  // count edge (E2). Optionally checks that tcnt holds until E2.
  task automatic tick_ev(input logic we, input logic [7:0] din, input logic oclr,
                         input logic tclr, input logic lat_chk, input logic [7:0] before_v);
    tick_in = 1'b1;
    @(negedge clock50);
    if (lat_chk) check_eq("lat_after_E0", {24'd0, tcnt}, {24'd0, before_v});
    @(negedge clock50);
    if (lat_chk) check_eq("lat_after_E1", {24'd0, tcnt}, {24'd0, before_v});
    tcnt_we  = we;
    tcnt_din = din;
    ocf_clr  = oclr;
    tov_clr  = tclr;
    @(negedge clock50);
    tcnt_we = 1'b0;
    ocf_clr = 1'b0;
    tov_clr = 1'b0;
    @(negedge clock50);
    tick_in = 1'b0;
    idle(3);
  endtask

  task automatic tick();
    tick_ev(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic write_tcnt(input logic [7:0] v);
    tcnt_we  = 1'b1;
    tcnt_din = v;
    @(negedge clock50);
    tcnt_we = 1'b0;
    @(negedge clock50);
  endtask

  task automatic pulse_clr(input logic t, input logic o);
    tov_clr = t;
    ocf_clr = o;
    @(negedge clock50);
    tov_clr = 1'b0;
    ocf_clr = 1'b0;
    @(negedge clock50);
  endtask

  initial begin
    logic [7:0] ctc_seq [12];
    logic [7:0] held;
    ctc_seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1, 8'd2};
    MR_n = 1'b0; tick_in = 1'b0; cs = 3'd0; ctc = 1'b0; ocr = 8'hAA;
    tcnt_we = 1'b0; tcnt_din = 8'h00; tov_clr = 1'b0; ocf_clr = 1'b0;
    exp_oc = 1'b0;
    idle(3);
    check_eq("rst_tcnt", {24'd0, tcnt}, 32'h0);
    check_eq("rst_tov", {31'd0, tov}, 32'h0);
    check_eq("rst_ocf", {31'd0, ocf}, 32'h0);
    check_eq("rst_oc", {31'd0, oc_out}, 32'h0);
    MR_n = 1'b1;
    cs = 3'd1;
    idle(2);

    // Count a little, then make flags nonzero and reset asynchronously mid-cycle.
    tick();
    tick();
    check_eq("pre_rst_tcnt", {24'd0, tcnt}, 32'h2);
    ocr = 8'h02;
    tick();
    check_eq("pre_rst_ocf", {31'd0, ocf}, 32'h1);
    ocr = 8'hAA;
    #2 MR_n = 1'b0;
    #1;
    check_eq("async_rst_tcnt", {24'd0, tcnt}, 32'h0);
    check_eq("async_rst_ocf", {31'd0, ocf}, 32'h0);
    check_eq("async_rst_oc", {31'd0, oc_out}, 32'h0);
    @(negedge clock50);
    MR_n = 1'b1;
    idle(2);

    // Three ticks after reset, each with its latency checked.
    for (int i = 0; i < 3; i++) begin
      tick_ev(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'(i));
      check_eq("post_rst_count", {24'd0, tcnt}, i + 1);
    end

    // Normal-mode overflow.
    write_tcnt(8'hFE);
    tick();
    check_eq("ovf_ff", {24'd0, tcnt}, 32'hFF);
    check_eq("ovf_tov0", {31'd0, tov}, 32'h0);
    tick();
    check_eq("ovf_00", {24'd0, tcnt}, 32'h00);
    check_eq("ovf_tov1", {31'd0, tov}, 32'h1);
    pulse_clr(1'b1, 1'b0);
    check_eq("tov_clr", {31'd0, tov}, 32'h0);

    // CTC with ocr=4.
    ctc = 1'b1; ocr = 8'd4;
    idle(1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("ctc_seq", {24'd0, tcnt}, {24'd0, ctc_seq[i]});
      if (i == 3) check_eq("ctc_ocf_pre", {31'd0, ocf}, 32'h0);
      if (i == 4) check_eq("ctc_ocf_set", {31'd0, ocf}, 32'h1);
      if (i == 4) check_eq("ctc_oc_1", {31'd0, oc_out}, 32'h1);
      if (i == 9) check_eq("ctc_oc_2", {31'd0, oc_out}, 32'h0);
    end
    check_eq("ctc_no_tov", {31'd0, tov}, 32'h0);
    pulse_clr(1'b0, 1'b1);
    check_eq("ctc_ocf_clr", {31'd0, ocf}, 32'h0);

    // Prescaler /8 then /64 restart.
    ctc = 1'b0; ocr = 8'hAA; cs = 3'd2;
    write_tcnt(8'h00);
    for (int i = 0; i < 16; i++) tick();
    check_eq("div8_16", {24'd0, tcnt}, 32'h2);
    for (int i = 0; i < 3; i++) tick();
    check_eq("div8_19", {24'd0, tcnt}, 32'h2);
    cs = 3'd3;
    idle(2);
    for (int i = 0; i < 63; i++) tick();
    check_eq("div64_63", {24'd0, tcnt}, 32'h2);
    tick();
    check_eq("div64_64", {24'd0, tcnt}, 32'h3);

    // Write collides with a wrapping count event.
    cs = 3'd1;
    idle(2);
    write_tcnt(8'hFF);
    tick_ev(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("coll_we_tcnt", {24'd0, tcnt}, 32'h10);
    check_eq("coll_we_tov", {31'd0, tov}, 32'h0);

    // ocf_clr collides with a match.
    ocr = 8'h12;
    write_tcnt(8'h12);
    tick_ev(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    check_eq("coll_clr_ocf", {31'd0, ocf}, 32'h1);
    check_eq("coll_clr_tcnt", {24'd0, tcnt}, 32'h13);
    check_eq("coll_clr_oc", {31'd0, oc_out}, 32'h1);
    exp_oc = 1'b1;

    // Reserved clock select freezes the counter.
    ocr = 8'hAA; cs = 3'd6;
    held = tcnt;
    idle(2);
    for (int i = 0; i < 20; i++) tick();
    check_eq("stop_cs6", {24'd0, tcnt}, 32'h13);

    // CTC with ocr=0: holds 0, every event matches.
    cs = 3'd1; ctc = 1'b1; ocr = 8'h00;
    idle(2);
    write_tcnt(8'h00);
    pulse_clr(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_oc = ~exp_oc;
      check_eq("ocr0_tcnt", {24'd0, tcnt}, 32'h0);
      check_eq("ocr0_ocf", {31'd0, ocf}, 32'h1);
      check_eq("ocr0_oc", {31'd0, oc_out}, {31'd0, exp_oc});
      pulse_clr(1'b0, 1'b1);
      check_eq("ocr0_ocf_clr", {31'd0, ocf}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
